// File: rtl/tcdm_chan_mux.sv
// tcdm_chan_mux: funnels NB_CHAN streamer TCDM channels onto one TCDM master
// port. The arbiter is either work-conserving round-robin or a programmed
// slot sequence that has a repeatable loop section. Responses are steered
// back to the channels through an in-order FIFO of channel ids, so the TCDM
// response latency can be any number of cycles from one upward.
module tcdm_chan_mux #(
  parameter int unsigned NB_CHAN         = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned SCHED_LEN       = 8,
  localparam int unsigned CW = $clog2(NB_CHAN),
  localparam int unsigned SW = $clog2(SCHED_LEN),
  localparam int unsigned BW = DATA_WIDTH / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       mode_i,
  input  logic [SCHED_LEN*CW-1:0]    sched_chan_i,
  input  logic [SW:0]                sched_len_i,
  input  logic [SW-1:0]              loop_end_i,
  input  logic [15:0]                loop_cnt_i,
  input  logic [NB_CHAN-1:0]         chan_req_i,
  input  logic [NB_CHAN-1:0]         chan_wen_i,
  input  logic [NB_CHAN*ADDR_WIDTH-1:0] chan_add_i,
  input  logic [NB_CHAN*DATA_WIDTH-1:0] chan_data_i,
  input  logic [NB_CHAN*BW-1:0]      chan_be_i,
  output logic [NB_CHAN-1:0]         chan_gnt_o,
  output logic [NB_CHAN-1:0]         chan_r_valid_o,
  output logic [DATA_WIDTH-1:0]      chan_r_data_o,
  output logic                       tcdm_req_o,
  output logic                       tcdm_wen_o,
  output logic [ADDR_WIDTH-1:0]      tcdm_add_o,
  output logic [DATA_WIDTH-1:0]      tcdm_data_o,
  output logic [BW-1:0]              tcdm_be_o,
  input  logic                       tcdm_gnt_i,
  input  logic                       tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]      tcdm_r_data_i,
  output logic [CW-1:0]              cur_chan_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned NW = $clog2(MAX_OUTSTANDING + 1);

  logic          flush;
  logic [CW-1:0] rr_q, rr_sel, rr_idx, seq_sel, sel, lock_sel_q;
  logic          rr_found, lock_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [15:0]   iter_q, iter_d;
  logic [SW:0]   sched_last;
  logic [CW-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] cnt_q;
  logic          full, empty, req_out, grant, pop, err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reset and soft clear act identically; both also silence the master port.
  assign flush = rst_i | clear_i;

  // Round-robin choice: first requesting channel at or after rr_q, cyclically.
  // NOTE: every variable gets a default before any conditional write so no latch is inferred.
  always_comb begin
    rr_sel   = rr_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < NB_CHAN; i++) begin
      rr_idx = CW'((int'(rr_q) + i) % NB_CHAN);
      if (!rr_found && chan_req_i[rr_idx]) begin
        rr_sel   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign seq_sel    = sched_chan_i[slot_q*CW +: CW];
  assign sel        = lock_q ? lock_sel_q : (mode_i ? seq_sel : rr_sel);
  assign sched_last = sched_len_i - (SW+1)'(1);

  // Next slot/iteration of the programmed sequence, applied only on a grant.
  always_comb begin
    slot_d = slot_q;
    iter_d = iter_q;
    if (slot_q == loop_end_i) begin
      if (iter_q != loop_cnt_i) begin
        slot_d = '0;
        iter_d = iter_q + 16'd1;
      end else if ({1'b0, loop_end_i} == sched_last) begin
        slot_d = '0;
        iter_d = '0;
      end else begin
        slot_d = loop_end_i + SW'(1);
      end
    end else if ({1'b0, slot_q} == sched_last) begin
      slot_d = '0;
      iter_d = '0;
    end else begin
      slot_d = slot_q + SW'(1);
    end
  end

  // The full flag comes from the registered count, so a pop in the same cycle
  // cannot open a combinational path from r_valid to req.
  assign full    = (cnt_q == NW'(MAX_OUTSTANDING));
  assign empty   = (cnt_q == '0);
  assign req_out = ~flush & chan_req_i[sel] & ~full;
  assign grant   = req_out & tcdm_gnt_i;
  assign pop     = ~flush & tcdm_r_valid_i & ~empty;

  assign tcdm_req_o    = req_out;
  assign tcdm_wen_o    = chan_wen_i[sel];
  assign tcdm_add_o    = chan_add_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign tcdm_data_o   = chan_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign tcdm_be_o     = chan_be_i[sel*BW +: BW];
  assign chan_r_data_o = tcdm_r_data_i;
  assign cur_chan_o    = flush ? '0 : sel;
  assign busy_o        = ~flush & ~empty;
  assign err_o         = ~flush & err_q;

  // One-hot grant to the selected channel and response to the FIFO head.
  always_comb begin
    chan_gnt_o     = '0;
    chan_r_valid_o = '0;
    if (grant) chan_gnt_o[sel] = 1'b1;
    if (pop)   chan_r_valid_o[fifo_mem[rd_ptr_q]] = 1'b1;
  end

  // Arbiter state, lock, FIFO pointers/count and the sticky error flag.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      rr_q       <= '0;
      slot_q     <= '0;
      iter_q     <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= req_out & ~tcdm_gnt_i;
      lock_sel_q <= sel;
      if (grant) begin
        if (mode_i) begin
          slot_q <= slot_d;
          iter_q <= iter_d;
        end else begin
          rr_q <= (sel == CW'(NB_CHAN - 1)) ? '0 : sel + CW'(1);
        end
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({grant, pop})
        2'b10:   cnt_q <= cnt_q + NW'(1);
        2'b01:   cnt_q <= cnt_q - NW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (tcdm_r_valid_i && empty) err_q <= 1'b1;
    end
  end

  // ID FIFO storage: channel id of each granted request, oldest at rd_ptr_q.
  // NOTE: storage is not reset; occupancy is tracked by cnt_q, so stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (grant) fifo_mem[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_tcdm_chan_mux.sv
// Testbench for tcdm_chan_mux: a transaction-level model (grant order from an
// expanded slot list or a round-robin pointer, a queue of outstanding channel
// ids) is compared with the DUT every cycle, and directed scenarios pin the
// model with hand-computed grant orders and literal output values.
module tb_tcdm_chan_mux;

  localparam int NB = 4, AW = 32, DW = 32, BW = 4, MO = 2, SL = 8, CW = 2, SW = 3;

  logic clk = 1'b0;
  logic rst_i = 1'b1, clear_i = 1'b0, mode_i = 1'b0;
  logic [SL*CW-1:0] sched_chan_i = '0;
  logic [SW:0]      sched_len_i = 4'd1;
  logic [SW-1:0]    loop_end_i = '0;
  logic [15:0]      loop_cnt_i = '0;
  logic [NB-1:0]    chan_req_i = '0, chan_wen_i = 4'b0101;
  logic [NB*AW-1:0] chan_add_i = {32'h1000_000C, 32'h1000_0008, 32'h1000_0004, 32'h1000_0000};
  logic [NB*DW-1:0] chan_data_i = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
  logic [NB*BW-1:0] chan_be_i = 16'hF31C;
  logic [NB-1:0]    chan_gnt_o, chan_r_valid_o;
  logic [DW-1:0]    chan_r_data_o;
  logic             tcdm_req_o, tcdm_wen_o;
  logic [AW-1:0]    tcdm_add_o;
  logic [DW-1:0]    tcdm_data_o;
  logic [BW-1:0]    tcdm_be_o;
  logic             tcdm_gnt_i = 1'b1;
  logic             tcdm_r_valid_i;
  logic [DW-1:0]    tcdm_r_data_i = '0;
  logic [CW-1:0]    cur_chan_o;
  logic             busy_o, err_o;

  logic rv_auto = 1'b0, rv_spur = 1'b0;
  assign tcdm_r_valid_i = rv_auto | rv_spur;

  tcdm_chan_mux #(
    .NB_CHAN(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MO), .SCHED_LEN(SL)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .mode_i(mode_i),
    .sched_chan_i(sched_chan_i), .sched_len_i(sched_len_i),
    .loop_end_i(loop_end_i), .loop_cnt_i(loop_cnt_i),
    .chan_req_i(chan_req_i), .chan_wen_i(chan_wen_i), .chan_add_i(chan_add_i),
    .chan_data_i(chan_data_i), .chan_be_i(chan_be_i),
    .chan_gnt_o(chan_gnt_o), .chan_r_valid_o(chan_r_valid_o), .chan_r_data_o(chan_r_data_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_add_o(tcdm_add_o),
    .tcdm_data_o(tcdm_data_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .cur_chan_o(cur_chan_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Bench-side state: model, responder, logs.
  int seq_list[$];
  int m_rr = 0, m_pos = 0, m_lock_sel = 0;
  bit m_lock = 1'b0, m_err = 1'b0;
  int m_fifo[$];
  int due_q[$];
  int glog[$];
  int cyc = 0, out_cnt = 0, max_seen = 0;
  bit gnt_val = 1'b1, gnt_rand = 1'b0, lat_rand = 1'b0;
  logic [NB-1:0] last_gnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program the DUT and expand the slot program into the flat grant order of one pass.
  task automatic configure(input logic m, input logic [SL*CW-1:0] sc, input int len,
                           input int le, input int lc);
    mode_i       = m;
    sched_chan_i = sc;
    sched_len_i  = (SW+1)'(len);
    loop_end_i   = SW'(le);
    loop_cnt_i   = 16'(lc);
    seq_list.delete();
    for (int it = 0; it <= lc; it++)
      for (int k = 0; k <= le; k++) seq_list.push_back(int'(sc[k*CW +: CW]));
    for (int k = le + 1; k < len; k++) seq_list.push_back(int'(sc[k*CW +: CW]));
  endtask

  // Compare the first n logged grants with nibble-packed expected channels (entry 0 lowest).
  task automatic check_log(input string name, input logic [63:0] exp_vec, input int n);
    check({name, "_count"}, 64'(glog.size() >= n), 64'd1);
    for (int i = 0; i < n; i++)
      if (i < glog.size()) check(name, 64'(glog[i]), 64'(exp_vec[i*4 +: 4]));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    chan_req_i = '0;
    while ((busy_o || due_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", 64'(n < budget), 64'd1);
    tick();
  endtask

  // Every cycle: model outputs from the rules, compare, then advance model and responder.
  always @(negedge clk) begin
    bit flush, full, ereq, egrant, epop;
    int sel, lat, due;
    logic [NB-1:0] egnt, erv;
    flush = rst_i | clear_i;
    if (m_lock) sel = m_lock_sel;
    else if (mode_i) sel = (m_pos < seq_list.size()) ? seq_list[m_pos] : 0;
    else begin
      sel = m_rr;
      for (int k = NB - 1; k >= 0; k--)
        if (chan_req_i[CW'((m_rr + k) % NB)]) sel = (m_rr + k) % NB;
    end
    full   = m_fifo.size() >= MO;
    ereq   = !flush && chan_req_i[CW'(sel)] && !full;
    egrant = ereq && tcdm_gnt_i;
    epop   = !flush && tcdm_r_valid_i && m_fifo.size() > 0;
    egnt   = egrant ? (NB'(1) << sel) : '0;
    erv    = epop ? (NB'(1) << m_fifo[0]) : '0;

    check("tcdm_req", 64'(tcdm_req_o), 64'(ereq));
    check("chan_gnt", 64'(chan_gnt_o), 64'(egnt));
    check("chan_r_valid", 64'(chan_r_valid_o), 64'(erv));
    check("busy", 64'(busy_o), 64'(!flush && m_fifo.size() > 0));
    check("err", 64'(err_o), 64'(!flush && m_err));
    check("r_data", 64'(chan_r_data_o), 64'(tcdm_r_data_i));
    if (!flush) check("cur_chan", 64'(cur_chan_o), 64'(sel));
    if (ereq) begin
      check("tcdm_add", 64'(tcdm_add_o), 64'(chan_add_i[sel*AW +: AW]));
      check("tcdm_wen", 64'(tcdm_wen_o), 64'(chan_wen_i[CW'(sel)]));
      check("tcdm_data", 64'(tcdm_data_o), 64'(chan_data_i[sel*DW +: DW]));
      check("tcdm_be", 64'(tcdm_be_o), 64'(chan_be_i[sel*BW +: BW]));
    end

    for (int k = 0; k < NB; k++) if (chan_gnt_o[k]) glog.push_back(k);
    out_cnt += $countones(chan_gnt_o) - $countones(chan_r_valid_o);
    if (out_cnt > max_seen) max_seen = out_cnt;
    last_gnt = chan_gnt_o;

    if (tcdm_req_o && tcdm_gnt_i) begin
      lat = lat_rand ? int'($urandom_range(1, 4)) : 1;
      due = cyc + lat;
      if (due_q.size() > 0 && due <= due_q[$]) due = due_q[$] + 1;
      due_q.push_back(due);
    end

    if (flush) begin
      m_rr = 0; m_pos = 0; m_lock = 1'b0; m_err = 1'b0;
      m_fifo.delete();
    end else begin
      if (tcdm_r_valid_i && !epop) m_err = 1'b1;
      if (epop) void'(m_fifo.pop_front());
      if (egrant) begin
        m_fifo.push_back(sel);
        if (mode_i) m_pos = (m_pos + 1) % seq_list.size();
        else        m_rr  = (sel + 1) % NB;
      end
      m_lock     = ereq && !tcdm_gnt_i;
      m_lock_sel = sel;
    end
  end

  // TCDM slave: drives gnt and returns in-order responses on their due cycle.
  always @(posedge clk) begin
    #2;
    cyc++;
    tcdm_gnt_i    = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_val;
    tcdm_r_data_i = $urandom;
    rv_auto       = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      rv_auto = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values with every channel requesting.
    configure(1'b0, '0, 1, 0, 0);
    chan_req_i = '1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_tcdm_req", 64'(tcdm_req_o), 64'd0);
    check("reset_chan_gnt", 64'(chan_gnt_o), 64'd0);
    check("reset_chan_r_valid", 64'(chan_r_valid_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);
    check("reset_cur_chan", 64'(cur_chan_o), 64'd0);

    // Round-robin, gnt always 1, one-cycle responses.
    tick();
    rst_i = 1'b0;
    glog.delete();
    @(negedge clk);
    check("rr_first_gnt", 64'(chan_gnt_o), 64'h1);
    check("rr_first_add", 64'(tcdm_add_o), 64'h1000_0000);
    check("rr_first_r_valid", 64'(chan_r_valid_o), 64'h0);
    tick();
    @(negedge clk);
    check("rr_second_gnt", 64'(chan_gnt_o), 64'h2);
    check("rr_second_r_valid", 64'(chan_r_valid_o), 64'h1);
    repeat (4) tick();
    drain(50);
    check_log("rr_order", 64'h03210, 5);

    // Sequence A,B looped three times, then C, D.
    configure(1'b1, 16'h00E4, 4, 1, 2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chan_req_i = '1;
    glog.delete();
    repeat (10) tick();
    drain(50);
    check_log("seq_order", 64'h032101010, 9);

    // Clear in the middle of the loop (slot 1, iteration 1).
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chan_req_i = '1;
    glog.delete();
    tick();
    tick();
    tick();
    clear_i = 1'b1;
    gnt_val = 1'b0;
    tick();
    clear_i = 1'b0;
    gnt_val = 1'b1;
    check_log("pre_clear_order", 64'h010, 3);
    glog.delete();
    @(negedge clk);
    check("busy_after_clear", 64'(busy_o), 64'd0);
    check("cur_chan_after_clear", 64'(cur_chan_o), 64'd0);
    repeat (6) tick();
    drain(50);
    check_log("post_clear_order", 64'h101010, 6);

    // Sequence slot for channel 2 idle while channel 0 requests: no skipping.
    tick();
    configure(1'b1, 16'h0002, 2, 0, 0);
    clear_i = 1'b1;
    chan_req_i = '0;
    tick();
    clear_i = 1'b0;
    chan_req_i = 4'b0001;
    glog.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_tcdm_req", 64'(tcdm_req_o), 64'd0);
      check("stall_chan_gnt", 64'(chan_gnt_o), 64'd0);
      tick();
    end
    chan_req_i = 4'b0101;
    repeat (3) tick();
    drain(50);
    check_log("stall_order", 64'h02, 2);

    // Round-robin with random gnt stalls and random response latency.
    tick();
    configure(1'b0, '0, 1, 0, 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    gnt_rand = 1'b1;
    lat_rand = 1'b1;
    out_cnt = 0;
    max_seen = 0;
    glog.delete();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NB; c++) begin
        if (!(chan_req_i[c] && !last_gnt[c])) begin
          chan_req_i[c] = 1'($urandom_range(0, 1));
          chan_wen_i[c] = 1'($urandom_range(0, 1));
          chan_add_i[c*AW +: AW]  = $urandom;
          chan_data_i[c*DW +: DW] = $urandom;
          chan_be_i[c*BW +: BW]   = 4'($urandom);
        end
      end
      tick();
    end
    gnt_rand = 1'b0;
    lat_rand = 1'b0;
    gnt_val = 1'b1;
    drain(100);
    check("random_max_outstanding", 64'(max_seen <= MO), 64'd1);
    check("random_activity", 64'(glog.size() > 50), 64'd1);

    // Spurious response with an empty FIFO sets the sticky error.
    tick();
    rv_spur = 1'b1;
    @(negedge clk);
    check("spur_r_valid", 64'(chan_r_valid_o), 64'd0);
    tick();
    rv_spur = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_held", 64'(err_o), 64'd1);
      tick();
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    @(negedge clk);
    check("err_cleared", 64'(err_o), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
